// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage and its register file.
// Build option DECODE_BYPASS_EN (see decode_stage.sv) does not affect this package.
package decode_stage_pkg;

  localparam int WORD = 32;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic {RUN, SQUASH} sq_state_e;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] instr;
    logic [WORD-1:0] imm;
    logic [WORD-1:0] rs1val;
    logic [WORD-1:0] rs2val;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            valid;
  } ex_reg_t;

  // Sign-extended RV32I immediate selected by the instruction format.
  function automatic logic [WORD-1:0] buildImm(input logic [WORD-1:0] instr);
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: buildImm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 buildImm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                buildImm = {{19{instr[31]}}, instr[31], instr[7],
                                            instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         buildImm = {instr[31:12], 12'b0};
      OP_JAL:                   buildImm = {{11{instr[31]}}, instr[31], instr[19:12],
                                            instr[20], instr[30:21], 1'b0};
      default:                  buildImm = '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode pipeline register contents plus the fetch enable returned by decode.
// Build option DECODE_BYPASS_EN does not affect this interface.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [WORD-1:0] pcD;
  logic [WORD-1:0] instrD;
  logic            validD;
  logic            enF;

  modport master (output pcD, output instrD, output validD, input enF);
  modport slave  (input pcD, input instrD, input validD, output enF);
endinterface

// File: rtl/decode_stage_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero.
// DECODE_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [WORD-1:0] rdata1_o,
  output logic [WORD-1:0] rdata2_o
);

  logic [WORD-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
`ifdef DECODE_BYPASS_EN
    if (we_i && waddr_i != 5'd0 && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i != 5'd0 && waddr_i == raddr2_i) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/flopr.sv
// Resettable enabled register, used for the decode-to-execute pipeline register.
// Build option DECODE_BYPASS_EN does not affect this module.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, immediate/control generation, load-use stall and redirect squash.
// DECODE_BYPASS_EN: forward writeback into reads instead of stalling on a writeback match.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  decode_stage_if.slave   fd,
  input  logic            PCSrcM_i,
  input  logic            regwriteW_i,
  input  logic [4:0]      rdW_i,
  input  logic [WORD-1:0] resultW_i,
  output logic [WORD-1:0] pcE_o,
  output logic [WORD-1:0] instrE_o,
  output logic [WORD-1:0] immE_o,
  output logic [WORD-1:0] rs1valE_o,
  output logic [WORD-1:0] rs2valE_o,
  output logic [4:0]      rdE_o,
  output logic            regwriteE_o,
  output logic            memreadE_o,
  output logic            memwriteE_o,
  output logic            validE_o
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [WORD-1:0] rs1Val, rs2Val;
  logic            regwrite, memread, memwrite, useRs1, useRs2;
  logic            loadUse, wbHazard, squash, hazard;
  sq_state_e       state_q;
  ex_reg_t         ex_d, ex_q;

  assign opcode = fd.instrD[6:0];
  assign rs1    = fd.instrD[19:15];
  assign rs2    = fd.instrD[24:20];
  assign rd     = fd.instrD[11:7];

  decode_stage_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (reset),
    .we_i     (regwriteW_i),
    .waddr_i  (rdW_i),
    .wdata_i  (resultW_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1Val),
    .rdata2_o (rs2Val)
  );

  // Field usage matters for hazards: U/J immediates overlap the rs1/rs2 bit positions.
  always_comb begin
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    useRs1   = 1'b0;
    useRs2   = 1'b0;
    case (opcode)
      OP_IMM, OP_JALR: begin regwrite = 1'b1; useRs1 = 1'b1; end
      OP_LOAD:         begin regwrite = 1'b1; memread = 1'b1; useRs1 = 1'b1; end
      OP_STORE:        begin memwrite = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; end
      OP_BRANCH:       begin useRs1 = 1'b1; useRs2 = 1'b1; end
      OP_REG:          begin regwrite = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: regwrite = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) regwrite = 1'b0;
  end

  assign loadUse = fd.validD && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                   ((useRs1 && rs1 == ex_q.rd) || (useRs2 && rs2 == ex_q.rd));

`ifdef DECODE_BYPASS_EN
  assign wbHazard = 1'b0;
`else
  assign wbHazard = fd.validD && regwriteW_i && (rdW_i != 5'd0) &&
                    ((useRs1 && rs1 == rdW_i) || (useRs2 && rs2 == rdW_i));
`endif

  // A redirect overrides any stall: the D slot is wrong-path and fetch must move on.
  assign squash = PCSrcM_i || (state_q == SQUASH);
  assign hazard = loadUse || wbHazard;
  assign fd.enF = squash || !hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:    if (PCSrcM_i) state_q <= SQUASH;
        SQUASH: state_q <= PCSrcM_i ? SQUASH : RUN;
      endcase
    end
  end

  // Bubbles are an all-zero E entry; the E register itself always advances.
  always_comb begin
    ex_d = '0;
    if (!squash && !hazard) begin
      ex_d.pc       = fd.pcD;
      ex_d.instr    = fd.instrD;
      ex_d.imm      = buildImm(fd.instrD);
      ex_d.rs1val   = rs1Val;
      ex_d.rs2val   = rs2Val;
      ex_d.rd       = rd;
      ex_d.regwrite = regwrite && fd.validD;
      ex_d.memread  = memread && fd.validD;
      ex_d.memwrite = memwrite && fd.validD;
      ex_d.valid    = fd.validD;
    end
  end

  flopr #(.WIDTH($bits(ex_reg_t))) u_exReg (
    .clk  (clk),
    .rst  (reset),
    .en_i (1'b1),
    .d_i  (ex_d),
    .q_o  (ex_q)
  );

  assign pcE_o       = ex_q.pc;
  assign instrE_o    = ex_q.instr;
  assign immE_o      = ex_q.imm;
  assign rs1valE_o   = ex_q.rs1val;
  assign rs2valE_o   = ex_q.rs2val;
  assign rdE_o       = ex_q.rd;
  assign regwriteE_o = ex_q.regwrite;
  assign memreadE_o  = ex_q.memread;
  assign memwriteE_o = ex_q.memwrite;
  assign validE_o    = ex_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an instruction-level pipeline model.
// Follows DECODE_BYPASS_EN the same way the design build does.
module tb_decode_stage;

`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] LW_X2   = 32'h0000A103;
  localparam logic [31:0] ADD_X3  = 32'h002101B3;
  localparam logic [31:0] ADD_X6  = 32'h00028333;
  localparam logic [31:0] ADDI_X7 = 32'h00000393;
  localparam logic [31:0] SW_X2   = 32'hFE20AE23;
  localparam logic [31:0] LUI_X8  = 32'h12345437;
  localparam logic [31:0] BEQ_M8  = 32'hFE208CE3;
  localparam logic [31:0] JAL_X5  = 32'h010002EF;
  localparam logic [31:0] UNKNOWN = 32'h0000007F;
  localparam logic [31:0] ADD_X0  = 32'h00108033;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, regwriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic [31:0] pcE, instrE, immE, rs1valE, rs2valE;
  logic [4:0]  rdE;
  logic        regwriteE, memreadE, memwriteE, validE;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  decode_stage_if fd();

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .fd          (fd),
    .PCSrcM_i    (PCSrcM),
    .regwriteW_i (regwriteW),
    .rdW_i       (rdW),
    .resultW_i   (resultW),
    .pcE_o       (pcE),
    .instrE_o    (instrE),
    .immE_o      (immE),
    .rs1valE_o   (rs1valE),
    .rs2valE_o   (rs2valE),
    .rdE_o       (rdE),
    .regwriteE_o (regwriteE),
    .memreadE_o  (memreadE),
    .memwriteE_o (memwriteE),
    .validE_o    (validE)
  );

  always #5 clk = ~clk;

  // Model: what the E slot must hold, derived from instruction formats and hazard rules.
  typedef struct packed {
    logic [31:0] pc, instr, imm, rs1v, rs2v;
    logic [4:0]  rd;
    logic        rw, mr, mw, v;
  } ex_t;

  ex_t         mE = '0;
  ex_t         nx;
  logic [31:0] mRegs [32];
  bit          mSquash = 1'b0;

  function automatic byte fmtOf(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return "I";
      7'h23:               return "S";
      7'h63:               return "B";
      7'h37, 7'h17:        return "U";
      7'h6F:               return "J";
      7'h33:               return "R";
      default:             return "?";
    endcase
  endfunction

  function automatic logic [31:0] immOf(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] hi;
    s = ins;
    case (fmtOf(ins[6:0]))
      "I": begin hi = s >>> 20; return hi; end
      "S": begin hi = s >>> 25; return (hi << 5) | {27'b0, ins[11:7]}; end
      "B": begin
        hi = s >>> 31;
        return (hi << 12) | ({31'b0, ins[7]} << 11) | ({26'b0, ins[30:25]} << 5) |
               ({28'b0, ins[11:8]} << 1);
      end
      "U": return ins & 32'hFFFF_F000;
      "J": begin
        hi = s >>> 31;
        return (hi << 20) | ({24'b0, ins[19:12]} << 12) | ({31'b0, ins[20]} << 11) |
               ({22'b0, ins[30:21]} << 1);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] regRead(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (BYPASS && regwriteW && rdW == r) return resultW;
    return mRegs[r];
  endfunction

  function automatic bit readsReg(input logic [31:0] ins, input logic [4:0] r);
    byte f;
    f = fmtOf(ins[6:0]);
    if (r == 5'd0) return 1'b0;
    if ((f == "I" || f == "S" || f == "B" || f == "R") && ins[19:15] == r) return 1'b1;
    if ((f == "S" || f == "B" || f == "R") && ins[24:20] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit hazardNow();
    if (!fd.validD) return 1'b0;
    if (mE.v && mE.mr && readsReg(fd.instrD, mE.rd)) return 1'b1;
    if (!BYPASS && regwriteW && readsReg(fd.instrD, rdW)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit expEnF();
    return PCSrcM || mSquash || !hazardNow();
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mE = '0;
      mSquash = 1'b0;
      foreach (mRegs[i]) mRegs[i] = 32'h0;
    end else begin
      byte f;
      f = fmtOf(fd.instrD[6:0]);
      nx = '0;
      if (!(PCSrcM || mSquash) && !hazardNow()) begin
        nx.pc    = fd.pcD;
        nx.instr = fd.instrD;
        nx.imm   = immOf(fd.instrD);
        nx.rs1v  = regRead(fd.instrD[19:15]);
        nx.rs2v  = regRead(fd.instrD[24:20]);
        nx.rd    = fd.instrD[11:7];
        nx.v     = fd.validD;
        nx.rw    = fd.validD && f != "S" && f != "B" && f != "?" && fd.instrD[11:7] != 5'd0;
        nx.mr    = fd.validD && fd.instrD[6:0] == 7'h03;
        nx.mw    = fd.validD && f == "S";
      end
      if (regwriteW && rdW != 5'd0) mRegs[rdW] = resultW;
      mSquash = PCSrcM;
      mE = nx;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("validE", {31'b0, validE}, {31'b0, mE.v});
      checkOutput("enF", {31'b0, fd.enF}, {31'b0, expEnF()});
      checkOutput("regwriteE", {31'b0, regwriteE}, {31'b0, mE.rw});
      checkOutput("memreadE", {31'b0, memreadE}, {31'b0, mE.mr});
      checkOutput("memwriteE", {31'b0, memwriteE}, {31'b0, mE.mw});
      if (mE.v) begin
        checkOutput("pcE", pcE, mE.pc);
        checkOutput("instrE", instrE, mE.instr);
        checkOutput("immE", immE, mE.imm);
        checkOutput("rs1valE", rs1valE, mE.rs1v);
        checkOutput("rs2valE", rs2valE, mE.rs2v);
        checkOutput("rdE", {27'b0, rdE}, {27'b0, mE.rd});
      end
    end
  end

  // Drives one decode slot plus writeback after a posedge, returns at the following negedge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr, input bit v,
                               input bit pcsrc, input bit rw, input logic [4:0] rd,
                               input logic [31:0] res);
    @(posedge clk);
    #2;
    fd.pcD = pc;
    fd.instrD = instr;
    fd.validD = v;
    PCSrcM = pcsrc;
    regwriteW = rw;
    rdW = rd;
    resultW = res;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    fd.pcD = '0; fd.instrD = '0; fd.validD = 1'b0;
    PCSrcM = 1'b0; regwriteW = 1'b0; rdW = '0; resultW = '0;
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    checkOutput("rst_validE", {31'b0, validE}, 32'd0);
    checkOutput("rst_enF", {31'b0, fd.enF}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h100);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22);

    applyStimulus(32'h10, ADDI_X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h14, LW_X2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("addi_pcE", pcE, 32'h10);
    checkOutput("addi_immE", immE, 32'd5);
    checkOutput("addi_rdE", {27'b0, rdE}, 32'd1);
    checkOutput("addi_regwriteE", {31'b0, regwriteE}, 32'd1);
    checkOutput("addi_validE", {31'b0, validE}, 32'd1);

    applyStimulus(32'h18, ADD_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("loaduse_enF", {31'b0, fd.enF}, 32'd0);
    applyStimulus(32'h18, ADD_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("loaduse_bubble", {31'b0, validE}, 32'd0);
    checkOutput("loaduse_release", {31'b0, fd.enF}, 32'd1);
    applyStimulus(32'h1C, LW_X2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("add_validE", {31'b0, validE}, 32'd1);
    checkOutput("add_rs1valE", rs1valE, 32'h22);
    checkOutput("add_rdE", {27'b0, rdE}, 32'd3);

    applyStimulus(32'h20, ADD_X3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("redirect_enF", {31'b0, fd.enF}, 32'd1);
    applyStimulus(32'h24, ADDI_X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("squash1_validE", {31'b0, validE}, 32'd0);
    applyStimulus(32'h40, ADDI_X7, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("squash2_validE", {31'b0, validE}, 32'd0);
    checkOutput("squash2_enF", {31'b0, fd.enF}, 32'd1);
    idle();
    checkOutput("after_squash_pcE", pcE, 32'h40);
    checkOutput("after_squash_validE", {31'b0, validE}, 32'd1);

    applyStimulus(32'h50, ADD_X6, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
`ifdef DECODE_BYPASS_EN
    checkOutput("wb_enF", {31'b0, fd.enF}, 32'd1);
    idle();
`else
    checkOutput("wb_enF", {31'b0, fd.enF}, 32'd0);
    applyStimulus(32'h50, ADD_X6, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("wb_bubble", {31'b0, validE}, 32'd0);
    idle();
`endif
    checkOutput("wb_rs1valE", rs1valE, 32'hDEADBEEF);
    checkOutput("wb_rdE", {27'b0, rdE}, 32'd6);

    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
    applyStimulus(32'h60, ADDI_X7, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    idle();
    checkOutput("x0_rs1valE", rs1valE, 32'h0);
    checkOutput("x0_validE", {31'b0, validE}, 32'd1);

    applyStimulus(32'h70, LUI_X8, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h74, BEQ_M8, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lui_immE", immE, 32'h12345000);
    applyStimulus(32'h78, JAL_X5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("beq_immE", immE, 32'hFFFFFFF8);
    checkOutput("beq_regwriteE", {31'b0, regwriteE}, 32'd0);
    applyStimulus(32'h7C, UNKNOWN, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("jal_immE", immE, 32'd16);
    applyStimulus(32'h80, ADD_X0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("unknown_immE", immE, 32'h0);
    checkOutput("unknown_validE", {31'b0, validE}, 32'd1);
    idle();
    checkOutput("rd0_regwriteE", {31'b0, regwriteE}, 32'd0);

    applyStimulus(32'h90, LW_X2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h94, ADD_X3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("pre_reset_enF", {31'b0, fd.enF}, 32'd0);
    #3 reset = 1'b1;
    #1;
    checkOutput("midstall_reset_validE", {31'b0, validE}, 32'd0);
    checkOutput("midstall_reset_enF", {31'b0, fd.enF}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    fd.validD = 1'b0;
    applyStimulus(32'hA0, SW_X2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    idle();
    checkOutput("sw_immE", immE, 32'hFFFFFFFC);
    checkOutput("sw_memwriteE", {31'b0, memwriteE}, 32'd1);
    checkOutput("sw_regwriteE", {31'b0, regwriteE}, 32'd0);
    checkOutput("sw_rs1valE", rs1valE, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage pipeline and the receiving end of the fetch→decode interface. Consumes the fetch pipeline register (`pcD`, `instrD`, `validD`), reads the 32-entry register file, and builds the RV32I immediate and control bits. Registers everything into the decode→execute pipeline register. Owns hazard control toward fetch: drives fetch's `en` low on a load-use stall, and squashes wrong-path instructions after an M-stage redirect (`PCSrcM`).

## Interface
- `NREGS`, 32, number of architectural registers; x0 is hardwired to zero.
- `clk` input 1, pipeline clock; all state updates on the rising edge.
- `reset` input 1, asynchronous, active-high; clears all state.
- `pcD` input `WORD, PC of the instruction in decode.
- `instrD` input `WORD, instruction word in decode.
- `validD` input 1, decode slot holds a real instruction.
- `PCSrcM` input 1, redirect taken in M; squash younger instructions.
- `regwriteW` input 1, writeback write enable.
- `rdW` input 5, writeback destination register.
- `resultW` input `WORD, writeback data.
- `enF` output 1, enable for fetch pc and fetch register; 0 = hold.
- `pcE`, `instrE`, `immE`, `rs1valE`, `rs2valE` output `WORD, execute-stage operands.
- `rdE` output 5, destination register.
- `regwriteE`, `memreadE`, `memwriteE`, `validE` output 1, execute-stage control.

## Operation
- Decode: opcode `instrD[6:0]`; rs1 `[19:15]`, rs2 `[24:20]`, rd `[11:7]`.
- Immediates, sign-extended to `WORD: I (0x13, 0x03, 0x67), S (0x23), B (0x63), U (0x37, 0x17), J (0x6F). Unknown opcode: imm = 0, all control bits 0, `validE` follows `validD`.
- `regwriteE` = 1 for I-ALU, R (0x33), load, U, JAL, JALR, but 0 when rd = 0. `memreadE` = 1 for load. `memwriteE` = 1 for store.
- Register file: write on rising edge when `regwriteW` and `rdW` ≠ 0. Reads of x0 always return 0.
- Load-use stall: when `memreadE & validE & rdE ≠ 0` and rdE equals a source register of a valid D instruction:
  - `enF` = 0;
  - E receives a bubble (`validE` = 0, all control bits 0);
  - D is held by fetch.
- Squash FSM with states RUN and SQUASH:
  - RUN → SQUASH when `PCSrcM` = 1. In that cycle E receives a bubble and stall is ignored (`enF` = 1).
  - SQUASH: the D slot is wrong-path, because fetch still latched the old pc. E receives a bubble and `enF` = 1. Go back to RUN.
  - `PCSrcM` while in SQUASH: stay in SQUASH for one more cycle.
- Priority: reset > `PCSrcM` / SQUASH > load-use stall > normal advance.

## Timing
- Latency: D → E is one cycle. `enF` is combinational from current D/E state.
- Reset values: all E outputs 0, `validE` = 0, FSM = RUN, register file all 0.
- Reset is asynchronous and may assert mid-stall or mid-SQUASH. On release the block starts in RUN with `enF` = 1.
- A load-use stall lasts exactly one cycle: the bubble clears `memreadE`.
- Writeback and decode read of the same register in the same cycle: see Configuration.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - register reads bypass combinationally from `resultW` when `regwriteW & rdW == rs & rs ≠ 0`;
  - no writeback stall.
- Not defined:
  - reads return stored array contents only;
  - add a one-cycle stall (same handling as load-use: `enF` = 0, bubble into E) when `regwriteW` matches a used nonzero source register of a valid D instruction.

## Structure
- Shared package holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG);
  - the `WORD width;
  - the E pipeline-register struct type.
- Sub-module `regfile`:
  - 2 read ports, 1 write port;
  - `NREGS` parameter;
  - bypass behaviour selected by `DECODE_BYPASS_EN`.
- The E register reuses `flopr` with `en`. Bubble insertion and squash are muxed on its `d` input.

## Test plan
- `addi x1,x0,5` (0x00500093), `validD` = 1, pcD = 0x10 → next cycle:
  - pcE = 0x10, immE = 5, rdE = 1, regwriteE = 1, validE = 1.
- `lw x2,0(x1)` followed by `add x3,x2,x2`:
  - while the add is in D, `enF` = 0 for one cycle, then `validE` = 0;
  - the next cycle the add enters E.
- `PCSrcM` pulse for 1 cycle:
  - `validE` = 0 for the 2 following cycles;
  - `enF` = 1 throughout;
  - FSM goes RUN→SQUASH→RUN.
- `regwriteW` = 1, `rdW` = 5, `resultW` = 0xDEADBEEF, with `add x6,x5,x0` in D:
  - bypass build: rs1valE = 0xDEADBEEF next cycle;
  - non-bypass build: one stall, then same value.
- Write to x0 with 0x1234, then read x0 → rs1valE = 0.
- Assert `reset` while a stall is active → `validE` = 0 and `enF` = 1 immediately. Store `sw x2,-4(x1)` after release → immE = 0xFFFFFFFC, memwriteE = 1, regwriteE = 0.
